// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: state encoding,
// frame-length helper and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Wide enough for DATA_BITS up to 9 and STOP_BITS up to 2.
  localparam int unsigned BIT_IDX_W = 4;

  function automatic int unsigned frame_cycles(
    input int unsigned data_bits,
    input int unsigned parity_bits,
    input int unsigned stop_bits,
    input int unsigned clks_per_bit
  );
    return (32'd1 + data_bits + parity_bits + stop_bits) * clks_per_bit;
  endfunction

  // Unused upper bits must be zero so they do not disturb the reduction.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous write buffer for the UART transmitter: WIDTH x DEPTH entries,
// registered occupancy count, writes on a full buffer are dropped.
module uart_tx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_rd,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  // Full is judged on the registered count only, so a same-edge pop never rescues a write.
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;

  // Storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with write FIFO. Optional parity bit is
// enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data_in,
  input  logic                 i_data_DV,
  output logic [DATA_BITS-1:0] o_data_in,
  output logic                 o_tx,
  output logic                 o_wait,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic [3:0]           debug
);
  import uart_pkg::*;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_fifo_param: PARITY_ODD must be 0 or 1");
  end

  uart_state_t            r_state, w_state_nxt;
  logic [BAUD_W-1:0]      r_baud, w_baud_nxt;
  logic [BIT_IDX_W-1:0]   r_bit_idx, w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_tx, w_tx_nxt;
  logic [DATA_BITS-1:0]   r_data_in;
  logic                   r_overflow;
  logic                   w_pop;
  logic                   w_load;
  logic                   w_baud_end;
  logic                   w_full;
  logic                   w_empty;
  logic [DATA_BITS-1:0]   w_rd_data;
  logic [CW-1:0]          w_count;
  logic                   w_accept;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity, w_par_nxt;
`endif

  assign w_accept = i_data_DV & ~w_full;

  uart_tx_fifo_buf #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (i_data_DV),
    .i_wdata (i_data_in),
    .i_rd    (w_pop),
    .o_rdata (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  // Next-state, serial bit and counter logic; w_load marks a pop into a new frame.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_load      = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        w_load     = ~w_empty;
      end
      ST_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
            w_bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
            w_tx_nxt    = r_parity;
`else
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_bit_nxt   = r_bit_idx + BIT_IDX_W'(1);
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == BIT_IDX_W'(STOP_BITS - 1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = ST_IDLE;
            w_load      = ~w_empty;
          end else begin
            w_bit_nxt = r_bit_idx + BIT_IDX_W'(1);
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // A pop always starts a frame straight away, from IDLE or from the end of STOP.
    if (w_load) begin
      w_state_nxt = ST_START;
      w_shift_nxt = w_rd_data;
      w_tx_nxt    = 1'b0;
      w_baud_nxt  = '0;
      w_bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = calc_parity(9'(w_rd_data), PARITY_ODD[0]);
`endif
    end else begin
      w_shift_nxt = w_shift_nxt;
    end
    w_pop = w_load;
  end

  // FSM and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_data_in  <= '0;
      r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_overflow <= i_data_DV & w_full;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_par_nxt;
`endif
      if (w_accept) begin
        r_data_in <= i_data_in;
      end
    end
  end

  assign o_tx       = r_tx;
  assign o_data_in  = r_data_in;
  assign o_wait     = w_full;
  assign o_overflow = r_overflow;
  assign o_busy     = (r_state != ST_IDLE) | (w_count != CW'(0));
  assign debug      = {1'b0, r_state};

endmodule
